// File: rtl/rx_inband_pkg.sv
// Shared definitions for the receive-side inband packetizer: header layout,
// packet geometry and FSM encoding.
package rx_inband_pkg;

    localparam int PKT_WORDS16   = 256;
    localparam int HDR_WORDS16   = 4;
    localparam int PAYLOAD_BYTES = 504;

    localparam int HDR_OVR_BIT   = 28;
    localparam int HDR_RSSI_LSB  = 16;
    localparam int HDR_CHAN_LSB  = 11;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE
    } rx_state_t;

    typedef struct packed {
        logic        ovr;
        logic [5:0]  rssi;
        logic [31:0] ts;
    } rx_hdr_t;

    function automatic logic [31:0] hdr_word0(input rx_hdr_t h, input logic [4:0] chan);
        logic [31:0] w;
        w = '0;
        w[HDR_OVR_BIT]          = h.ovr;
        w[HDR_RSSI_LSB +: 6]    = h.rssi;
        w[HDR_CHAN_LSB +: 5]    = chan;
        w[HDR_LEN_LSB +: 9]     = 9'(PAYLOAD_BYTES);
        return w;
    endfunction

endpackage

// File: rtl/rx_sample_fifo.sv
// Single-clock 32-bit sample FIFO with occupancy count; a push is still taken
// when full provided a pop happens in the same cycle.
module rx_sample_fifo #(
    parameter int DEPTH = 256,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          rxclk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [CW-1:0] count,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge rxclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rx_packet_assembler.sv
// Packs the strobed I/Q stream of one receive channel into 256-word inband
// packets (4 header words + 126 samples) for the RX USB FIFO interface.
module rx_packet_assembler
    import rx_inband_pkg::*;
#(
    parameter logic [4:0] CHAN_ID         = 5'd0,
    parameter int         FIFO_DEPTH      = 256,
    parameter int         PAYLOAD_SAMPLES = 126
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        rx_strobe,
    input  logic [15:0] rx_i,
    input  logic [15:0] rx_q,
    input  logic [31:0] adc_time,
    input  logic [31:0] rssi,
    input  logic        rx_WR_enabled,
    output logic [15:0] rx_databus,
    output logic        rx_WR,
    output logic        rx_WR_done,
    output logic        overrun,
    output logic [8:0]  fifo_level
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(PAYLOAD_SAMPLES);

    rx_state_t     state, state_nx;
    logic [7:0]    beat, beat_nx;
    logic [CW-1:0] level;
    logic          fifo_full, pop, accept, start;
    logic [31:0]   head, w0;
    logic [IW-1:0] in_cnt;
    logic [31:0]   ts_q [4];
    logic [1:0]    ts_wr, ts_rd;
    logic          ovr_pend;
    rx_hdr_t       hdr;
    logic [15:0]   word_nx;
    logic          wr_nx, done_nx;
    logic          unused_rssi;

    assign unused_rssi = ^rssi[31:6];
    assign fifo_level  = 9'(level);
    assign w0          = hdr_word0(hdr, CHAN_ID);

    // Odd payload beats carry Q, which retires the sample at the FIFO head.
    assign pop    = (state == ST_PAYLOAD) && beat[0];
    assign accept = rx_strobe && (!fifo_full || pop);

    rx_sample_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .rxclk (rxclk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .wdata ({rx_q, rx_i}),
        .rdata (head),
        .count (level),
        .full  (fifo_full)
    );

    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        start    = 1'b0;
        word_nx  = '0;
        wr_nx    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level >= CW'(PAYLOAD_SAMPLES) && rx_WR_enabled) begin
                    start    = 1'b1;
                    beat_nx  = '0;
                    state_nx = ST_HDR;
                end
            end
            ST_HDR: begin
                wr_nx   = 1'b1;
                beat_nx = beat + 8'd1;
                case (beat[1:0])
                    2'd0:    word_nx = w0[15:0];
                    2'd1:    word_nx = w0[31:16];
                    2'd2:    word_nx = hdr.ts[15:0];
                    default: word_nx = hdr.ts[31:16];
                endcase
                if (beat == 8'(HDR_WORDS16 - 1)) state_nx = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                wr_nx   = 1'b1;
                beat_nx = beat + 8'd1;
                word_nx = beat[0] ? head[31:16] : head[15:0];
                if (beat == 8'(PKT_WORDS16 - 1)) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            beat       <= '0;
            rx_databus <= '0;
            rx_WR      <= 1'b0;
            rx_WR_done <= 1'b0;
        end else begin
            state      <= state_nx;
            beat       <= beat_nx;
            rx_databus <= word_nx;
            rx_WR      <= wr_nx;
            rx_WR_done <= done_nx;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            in_cnt   <= '0;
            ts_wr    <= '0;
            ts_rd    <= '0;
            ovr_pend <= 1'b0;
            overrun  <= 1'b0;
            hdr      <= '0;
            for (int k = 0; k < 4; k++) ts_q[k] <= '0;
        end else begin
            overrun <= rx_strobe && !accept;
            if (accept) begin
                in_cnt <= (in_cnt == IW'(PAYLOAD_SAMPLES - 1)) ? '0 : in_cnt + IW'(1);
                if (in_cnt == '0) begin
                    ts_q[ts_wr] <= adc_time;
                    ts_wr       <= ts_wr + 2'd1;
                end
            end
            if (start) begin
                hdr.ts   <= ts_q[ts_rd];
                hdr.rssi <= rssi[5:0];
                hdr.ovr  <= ovr_pend;
                ts_rd    <= ts_rd + 2'd1;
            end
            // A drop in the start cycle must survive into the next header.
            if (rx_strobe && !accept) ovr_pend <= 1'b1;
            else if (start)           ovr_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_packet_assembler.sv
// Scoreboard bench: accepted samples and their timestamps are queued as they
// are driven, then popped and compared as packet words appear on rx_databus.
module tb_rx_packet_assembler;

    localparam logic [4:0] CHAN = 5'd5;

    logic        rxclk = 1'b0;
    logic        reset;
    logic        rx_strobe;
    logic [15:0] rx_i, rx_q;
    logic [31:0] adc_time, rssi;
    logic        rx_WR_enabled;
    logic [15:0] rx_databus;
    logic        rx_WR, rx_WR_done, overrun;
    logic [8:0]  fifo_level;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] exp_words[$];
    logic [31:0] exp_ts[$];
    int          in_mod = 0;
    bit          model_ovr = 1'b0;
    logic [15:0] smp = 16'd0;

    int          beat = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    int          ovr_seen = 0;
    logic [31:0] cur_w0, cur_ts, last_ts;

    rx_packet_assembler #(.CHAN_ID(CHAN), .FIFO_DEPTH(256), .PAYLOAD_SAMPLES(126)) dut (
        .rxclk         (rxclk),
        .reset         (reset),
        .rx_strobe     (rx_strobe),
        .rx_i          (rx_i),
        .rx_q          (rx_q),
        .adc_time      (adc_time),
        .rssi          (rssi),
        .rx_WR_enabled (rx_WR_enabled),
        .rx_databus    (rx_databus),
        .rx_WR         (rx_WR),
        .rx_WR_done    (rx_WR_done),
        .overrun       (overrun),
        .fifo_level    (fifo_level)
    );

    always #5 rxclk = ~rxclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: observe outputs at negedge, then release the strobe and advance time.
    task automatic tick();
        logic [31:0] w;
        @(negedge rxclk);
        if (overrun) ovr_seen++;
        if (rx_WR) wr_cnt++;
        if (reset) begin
            beat = 0;
        end else if (rx_WR) begin
            if (beat == 0) begin
                cur_w0 = {3'b0, model_ovr, 6'b0, rssi[5:0], CHAN, 2'b0, 9'd504};
                model_ovr = 1'b0;
                cur_ts = (exp_ts.size() != 0) ? exp_ts.pop_front() : 32'hxxxx_xxxx;
            end
            case (beat)
                0: chk("hdr_w0_lo", 32'(rx_databus), 32'(cur_w0[15:0]));
                1: chk("hdr_w0_hi", 32'(rx_databus), 32'(cur_w0[31:16]));
                2: begin chk("hdr_ts_lo", 32'(rx_databus), 32'(cur_ts[15:0])); last_ts[15:0] = rx_databus; end
                3: begin chk("hdr_ts_hi", 32'(rx_databus), 32'(cur_ts[31:16])); last_ts[31:16] = rx_databus; end
                default: begin
                    if (beat >= 256) chk("pkt_len", 32'(beat), 32'd255);
                    w = (exp_words.size() != 0) ? 32'(exp_words.pop_front()) : 32'hxxxx_xxxx;
                    chk($sformatf("payload_b%0d", beat), 32'(rx_databus), w);
                end
            endcase
            beat++;
        end else if (rx_WR_done) begin
            chk("done_after_256", 32'(beat), 32'd256);
            beat = 0;
            done_cnt++;
        end else if (beat != 0) begin
            chk("wr_contiguous", 32'(rx_WR), 32'd1);
        end
        rx_strobe = 1'b0;
        adc_time  = adc_time + 32'd1;
    endtask

    task automatic drive(input bit acc);
        rx_strobe = 1'b1;
        rx_i = smp;
        rx_q = ~smp;
        if (acc) begin
            if (in_mod == 0) exp_ts.push_back(adc_time);
            exp_words.push_back(rx_i);
            exp_words.push_back(rx_q);
            in_mod = (in_mod + 1) % 126;
        end else begin
            model_ovr = 1'b1;
        end
        smp = smp + 16'd1;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin tick(); t++; end
        chk("done_count", 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_beat(input int b);
        int t = 0;
        while (beat != b && t < 1000) begin tick(); t++; end
        chk($sformatf("reach_beat%0d", b), 32'(beat), 32'(b));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, d0, w0c;
        reset = 1'b1; rx_strobe = 1'b0; rx_i = '0; rx_q = '0;
        adc_time = 32'd100; rssi = 32'hFFFF_FFE5; rx_WR_enabled = 1'b0;
        repeat (3) tick();
        chk("rst_databus", 32'(rx_databus), 32'd0);
        chk("rst_wr", 32'(rx_WR), 32'd0);
        chk("rst_done", 32'(rx_WR_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        reset = 1'b0;
        tick();

        // Continuous stream, one packet.
        rx_WR_enabled = 1'b1;
        for (int i = 0; i < 126; i++) begin tick(); drive(1'b1); end
        wait_done(1);
        tick();
        chk("drain_level", 32'(fifo_level), 32'd0);

        // Overfill while blocked, then a strobe on the first Q-beat pop at full.
        rx_WR_enabled = 1'b0;
        ovr_seen = 0;
        w0c = wr_cnt;
        for (int i = 0; i < 259; i++) begin tick(); drive(i < 256); end
        repeat (3) tick();
        chk("ovr_pulses", 32'(ovr_seen), 32'd3);
        chk("full_level", 32'(fifo_level), 32'd256);
        chk("no_wr_blocked", 32'(wr_cnt - w0c), 32'd0);
        rx_WR_enabled = 1'b1;
        t = 0;
        while (!rx_WR && t < 50) begin tick(); t++; end
        chk("pkt_start", 32'(rx_WR), 32'd1);
        repeat (4) tick();
        drive(1'b1);
        tick();
        chk("full_pop_no_ovr", 32'(overrun), 32'd0);
        chk("full_pop_level", 32'(fifo_level), 32'd256);
        wait_done(3);
        tick();
        chk("residual_level", 32'(fifo_level), 32'd5);

        // Enable dropped mid-packet: packet completes, nothing restarts.
        rssi = 32'h0000_0012;
        for (int i = 0; i < 121; i++) begin tick(); drive(1'b1); end
        wait_beat(100);
        rx_WR_enabled = 1'b0;
        wait_done(4);
        w0c = wr_cnt;
        for (int i = 0; i < 126; i++) begin tick(); drive(1'b1); end
        repeat (20) tick();
        chk("no_start_disabled", 32'(wr_cnt - w0c), 32'd0);
        chk("held_level", 32'(fifo_level), 32'd126);
        rx_WR_enabled = 1'b1;
        wait_done(5);
        tick();
        chk("drain_level2", 32'(fifo_level), 32'd0);

        // Reset in the middle of a packet.
        for (int i = 0; i < 126; i++) begin tick(); drive(1'b1); end
        wait_beat(50);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("rst_mid_wr", 32'(rx_WR), 32'd0);
        chk("rst_mid_level", 32'(fifo_level), 32'd0);
        exp_words.delete(); exp_ts.delete(); in_mod = 0; model_ovr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_no_done", 32'(done_cnt), 32'(d0));
        for (int i = 0; i < 126; i++) begin tick(); drive(1'b1); end
        wait_done(d0 + 1);

        // Timestamp wrap with sparse strobes.
        d0 = done_cnt;
        tick();
        adc_time = 32'hFFFF_FFF0;
        drive(1'b1);
        for (int i = 1; i < 252; i++) begin repeat (4) tick(); drive(1'b1); end
        wait_done(d0 + 2);
        chk("ts_wrap", last_ts, 32'h0000_01E8);
        tick();
        chk("final_level", 32'(fifo_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
